// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and types for the FIFO write-side blocks
package fifo_pkg;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_MAX_BURST  = 8;
    localparam int REQ_IDX_W      = $clog2(DEF_NUM_REQ);
    typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request at or after the round-robin pointer, with wrap-around
module rr_priority_pick
    import fifo_pkg::*;
#(
    parameter int N = DEF_NUM_REQ,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_idx,
    output logic         o_found
);
    logic [2*N-1:0] w_dbl;
    logic [W:0]     w_sum;
    // rotate so the pointer position lands on bit 0, then take the lowest set bit
    always_comb begin
        w_dbl   = {i_req, i_req} >> i_ptr;
        w_sum   = '0;
        o_found = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_dbl[j]) begin
                w_sum   = {1'b0, i_ptr} + (W+1)'(j);
                o_found = 1'b1;
            end
        end
        o_idx = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : w_sum[W-1:0];
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of the fifo_memory write port among requesters
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int  NUM_REQ    = DEF_NUM_REQ,
    parameter int  FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int  MAX_BURST  = DEF_MAX_BURST,
    localparam int IW         = $clog2(NUM_REQ),
    localparam int CW         = $clog2(MAX_BURST) + 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] i_din,
    input  logic                          i_full,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic                          o_wen_a,
    output logic [FIFO_WIDTH-1:0]         o_din_a,
    output logic [IW-1:0]                 o_owner_id,
    output logic                          o_busy
);
    arb_state_t    r_state, w_state_nx;
    logic [IW-1:0] r_owner, r_rr_ptr, w_owner_nx, w_rr_ptr_nx, w_pick;
    logic [CW-1:0] r_burst_cnt, w_burst_cnt_nx;
    logic          w_found, w_own_req, w_last;

    rr_priority_pick #(.N(NUM_REQ), .W(IW)) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    assign o_busy     = r_state == BUSY;
    assign w_own_req  = i_req[r_owner];
    assign o_wen_a    = o_busy & w_own_req & ~i_full;
    assign o_gnt      = o_busy ? NUM_REQ'(1) << r_owner : '0;
    assign o_ack      = o_gnt & {NUM_REQ{o_wen_a}};
    assign o_din_a    = o_busy ? i_din[r_owner*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    assign o_owner_id = r_owner;
    assign w_last     = o_wen_a && r_burst_cnt == CW'(MAX_BURST - 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_owner     <= w_owner_nx;
            r_rr_ptr    <= w_rr_ptr_nx;
            r_burst_cnt <= w_burst_cnt_nx;
        end
    end

    // a full FIFO only stalls the owner; the grant ends on request drop or burst limit
    always_comb begin
        w_state_nx     = r_state;
        w_owner_nx     = r_owner;
        w_rr_ptr_nx    = r_rr_ptr;
        w_burst_cnt_nx = r_burst_cnt;
        if (r_state == IDLE) begin
            if (w_found) begin
                w_state_nx     = BUSY;
                w_owner_nx     = w_pick;
                w_burst_cnt_nx = '0;
            end
        end else if (!w_own_req || w_last) begin
            w_state_nx  = IDLE;
            w_rr_ptr_nx = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
        end else if (o_wen_a) begin
            w_burst_cnt_nx = r_burst_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: randomized and directed checks against a behavioural arbiter model
module tb_fifo_write_arbiter;
    localparam int N = 4, W = 16, MB = 8;
    logic           clk = 1'b0, rst_n = 1'b0, full = 1'b0;
    logic [N-1:0]   req = '0, gnt, ack;
    logic [N*W-1:0] din;
    logic           wen_a, busy;
    logic [W-1:0]   din_a;
    logic [1:0]     owner_id;
    logic [15:0]    p_seq [N] = '{default: 16'h0};
    logic [15:0]    m_seq [N] = '{default: 16'h0};
    int             checks = 0, failures = 0;
    int             m_busy = 0, m_owner = 0, m_next = 0, m_words = 0;
    logic [27:0]    exp_v, act_v;
    logic           exp_wen;
    int             grants[$];
    logic [W-1:0]   fifo_q[$];

    function automatic logic [W-1:0] word(int i, logic [15:0] s);
        return {i[3:0], s[11:0]};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_prod
        assign din[g*W +: W] = word(g, p_seq[g]);
    end

    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (ack[i]) p_seq[i] <= p_seq[i] + 16'd1;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_din      (din),
        .i_full     (full),
        .o_gnt      (gnt),
        .o_ack      (ack),
        .o_wen_a    (wen_a),
        .o_din_a    (din_a),
        .o_owner_id (owner_id),
        .o_busy     (busy)
    );

    task automatic cyc_begin();
        logic [1:0] o;
        #1;
        o       = 2'(m_owner);
        exp_wen = m_busy != 0 && req[o] && !full;
        exp_v   = {m_busy != 0 ? 4'(1 << m_owner) : 4'b0, exp_wen ? 4'(1 << m_owner) : 4'b0, exp_wen,
                   m_busy != 0 ? word(m_owner, m_seq[m_owner]) : 16'h0, m_busy != 0, m_busy != 0 ? o : 2'b0};
        act_v   = {gnt, ack, wen_a, din_a, busy, busy ? owner_id : 2'b0};
    endtask

    task automatic cyc_end();
        logic [1:0] ix;
        if (wen_a) fifo_q.push_back(din_a);
        if (m_busy != 0) begin
            if (exp_wen) begin
                m_seq[m_owner] = m_seq[m_owner] + 16'd1;
                m_words++;
            end
            if (!req[2'(m_owner)] || m_words == MB) begin
                m_busy = 0;
                m_next = (m_owner + 1) % N;
            end
        end else begin
            for (int k = 0; k < N && m_busy == 0; k++) begin
                ix = 2'((m_next + k) % N);
                if (req[ix]) begin
                    m_busy  = 1;
                    m_owner = int'(ix);
                    m_words = 0;
                    grants.push_back(int'(ix));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        full = 1'b0;
        m_busy = 0; m_next = 0; m_words = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({gnt, ack, wen_a, din_a, busy, owner_id} !== 28'h0) begin
            failures++;
            $display("FAIL reset_init got=%h exp=0", {gnt, ack, wen_a, din_a, busy, owner_id});
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            cyc_begin();
            checks++;
            if (act_v !== exp_v) begin failures++; $display("FAIL reset_pre cyc=%0d got=%h exp=%h", c, act_v, exp_v); end
            cyc_end();
        end
        #3;
        checks++;
        if (wen_a !== 1'b1) begin failures++; $display("FAIL reset_pre_wen got=%b exp=1", wen_a); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, wen_a, din_a, busy, owner_id} !== 28'h0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", {gnt, ack, wen_a, din_a, busy, owner_id});
        end
        do_reset();
        grants.delete();
        req = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            cyc_begin();
            checks++;
            if (act_v !== exp_v) begin failures++; $display("FAIL reset_post cyc=%0d got=%h exp=%h", c, act_v, exp_v); end
            cyc_end();
        end
        checks++;
        if (grants.size() != 1 || grants[0] != 0) begin
            failures++;
            $display("FAIL reset_first_grant got=%0d exp=0", grants.size() > 0 ? grants[0] : -1);
        end
    endtask

    task automatic test_single();
        int n = 0;
        do_reset();
        grants.delete();
        req = 4'b0100;
        for (int c = 0; c < 18; c++) begin
            cyc_begin();
            checks++;
            if (act_v !== exp_v) begin failures++; $display("FAIL single cyc=%0d got=%h exp=%h", c, act_v, exp_v); end
            if (wen_a && ack[2]) n++;
            cyc_end();
        end
        checks++;
        if (n != 16) begin failures++; $display("FAIL single_writes got=%0d exp=16", n); end
        checks++;
        if (grants.size() != 2 || grants[0] != 2 || grants[1] != 2) begin
            failures++;
            $display("FAIL single_grants got=%0d exp=2", grants.size());
        end
    endtask

    task automatic test_all_rr();
        int n = 0;
        do_reset();
        grants.delete();
        req = 4'b1111;
        for (int c = 0; c < 36; c++) begin
            cyc_begin();
            checks++;
            if (act_v !== exp_v) begin failures++; $display("FAIL all_rr cyc=%0d got=%h exp=%h", c, act_v, exp_v); end
            if (wen_a) n++;
            cyc_end();
        end
        checks++;
        if (n != 32) begin failures++; $display("FAIL all_rr_writes got=%0d exp=32", n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grants.size() != 4 || grants[i] != i) begin
                failures++;
                $display("FAIL all_rr_order idx=%0d got=%0d exp=%0d", i, grants.size() > i ? grants[i] : -1, i);
            end
        end
    endtask

    task automatic test_full_stall();
        int n = 0, stall_wen = 0, stall_gnt = 0;
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 15; c++) begin
            full = c >= 3 && c < 8;
            cyc_begin();
            checks++;
            if (act_v !== exp_v) begin failures++; $display("FAIL full_stall cyc=%0d got=%h exp=%h", c, act_v, exp_v); end
            if (wen_a) n++;
            if (full && wen_a) stall_wen++;
            if (full && gnt == 4'b0010) stall_gnt++;
            cyc_end();
        end
        full = 1'b0;
        checks++;
        if (n != 8) begin failures++; $display("FAIL full_stall_writes got=%0d exp=8", n); end
        checks++;
        if (stall_wen != 0) begin failures++; $display("FAIL full_stall_wen got=%0d exp=0", stall_wen); end
        checks++;
        if (stall_gnt != 5) begin failures++; $display("FAIL full_stall_gnt got=%0d exp=5", stall_gnt); end
    endtask

    task automatic test_release();
        int n = 0;
        do_reset();
        grants.delete();
        for (int c = 0; c < 7; c++) begin
            req = c == 0 ? 4'b1000 : c < 3 ? 4'b1001 : 4'b0001;
            cyc_begin();
            checks++;
            if (act_v !== exp_v) begin failures++; $display("FAIL release cyc=%0d got=%h exp=%h", c, act_v, exp_v); end
            if (ack[3]) n++;
            cyc_end();
        end
        checks++;
        if (n != 2) begin failures++; $display("FAIL release_writes got=%0d exp=2", n); end
        checks++;
        if (grants.size() != 2 || grants[0] != 3 || grants[1] != 0) begin
            failures++;
            $display("FAIL release_handoff got=%0d exp=0", grants.size() > 1 ? grants[1] : -1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            full = $urandom_range(0, 3) == 0;
            cyc_begin();
            checks++;
            if (act_v !== exp_v) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, act_v, exp_v); end
            cyc_end();
        end
        full = 1'b0;
    endtask

    task automatic test_fifo_fill();
        logic [15:0] s0 [N];
        logic [W-1:0] w;
        do_reset();
        fifo_q.delete();
        for (int i = 0; i < N; i++) s0[i] = m_seq[i];
        req = 4'b0011;
        for (int c = 0; c < 640; c++) begin
            full = fifo_q.size() >= 512;
            cyc_begin();
            checks++;
            if (act_v !== exp_v) begin failures++; $display("FAIL fifo_fill cyc=%0d got=%h exp=%h", c, act_v, exp_v); end
            cyc_end();
        end
        checks++;
        if (fifo_q.size() != 512) begin failures++; $display("FAIL fifo_fill_count got=%0d exp=512", fifo_q.size()); end
        while (fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            checks++;
            if (w[15:12] > 4'd1 || w[11:0] !== s0[w[13:12]][11:0]) begin
                failures++;
                $display("FAIL fifo_readback got=%h exp=%h", w, word(int'(w[13:12]), s0[w[13:12]]));
            end else begin
                s0[w[13:12]] = s0[w[13:12]] + 16'd1;
            end
        end
        req = '0;
        full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_rr();
        test_full_stall();
        test_release();
        test_random();
        test_fifo_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
